// File: rtl/edu_round_ctrl_pkg.sv
// Shared constants and state encoding for the edu_cell round sequencer.
package edu_round_ctrl_pkg;

    localparam int EDUCTRL_NUM_TKROW    = 8;
    localparam int EDUCTRL_TKROWADDR_BW = 3;
    localparam int EDUCTRL_SPIKE_TMO    = 16;

    typedef enum logic [2:0] {
        EDUCTRL_IDLE    = 3'd0,
        EDUCTRL_WAITBUF = 3'd1,
        EDUCTRL_ESMWR   = 3'd2,
        EDUCTRL_INIT    = 3'd3,
        EDUCTRL_SHIFT   = 3'd4,
        EDUCTRL_MATCH   = 3'd5,
        EDUCTRL_CLEAR   = 3'd6,
        EDUCTRL_FINISH  = 3'd7
    } educ_state_t;

endpackage

// File: rtl/edu_round_ctrl_if.sv
// Round-control bundle between the EDU top / cell array and the round sequencer.
interface edu_round_ctrl_if #(
    parameter int TKROW_BW = 3
);
    logic                round_start;
    logic                round_zero;
    logic                round_last;
    logic                all_aqmeasbuf_valid;
    logic                any_tokenmatch;
    logic                any_errormatch;
    logic                any_measmatch;
    logic                set_first_aqmeas;
    logic                wr_zeroesm;
    logic                pop_aqmeasbuf;
    logic                rst_cellstate;
    logic                shift_token;
    logic                token_finish;
    logic                token_in;
    logic                flag_in;
    logic                global_tokenmatch;
    logic                global_errormatch;
    logic                global_measmatch;
    logic                set_measerr_flag;
    logic                set_last_measerr_flag;
    logic                apply_aqmeas_flip;
    logic [TKROW_BW-1:0] curr_rowidx;
    logic                busy;
    logic                round_done;
    logic                tmo_err;

    modport master (
        input  round_start, round_zero, round_last, all_aqmeasbuf_valid,
               any_tokenmatch, any_errormatch, any_measmatch,
        output set_first_aqmeas, wr_zeroesm, pop_aqmeasbuf, rst_cellstate,
               shift_token, token_finish, token_in, flag_in,
               global_tokenmatch, global_errormatch, global_measmatch,
               set_measerr_flag, set_last_measerr_flag, apply_aqmeas_flip,
               curr_rowidx, busy, round_done, tmo_err
    );

    modport slave (
        output round_start, round_zero, round_last, all_aqmeasbuf_valid,
               any_tokenmatch, any_errormatch, any_measmatch,
        input  set_first_aqmeas, wr_zeroesm, pop_aqmeasbuf, rst_cellstate,
               shift_token, token_finish, token_in, flag_in,
               global_tokenmatch, global_errormatch, global_measmatch,
               set_measerr_flag, set_last_measerr_flag, apply_aqmeas_flip,
               curr_rowidx, busy, round_done, tmo_err
    );
endinterface

// File: rtl/edu_round_ctrl_match.sv
// Spike-phase timer: counts MATCH cycles and flags when the wait reaches SPIKE_TMO.
module edu_match_timer #(
    parameter int SPIKE_TMO = 16,
    parameter int TMO_BW    = $clog2(SPIKE_TMO + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tmo
);
    logic [TMO_BW-1:0] count;

    assign tmo = (count == TMO_BW'(SPIKE_TMO));

    // Saturates at the terminal value so a held MATCH cannot wrap the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !tmo) begin
            count <= count + TMO_BW'(1);
        end
    end
endmodule

// File: rtl/edu_round_ctrl.sv
// Round sequencer for the edu_cell array: buffer pop / zero-ESM, token sweep, spike handling.
module edu_round_ctrl
    import edu_round_ctrl_pkg::*;
#(
    parameter int NUM_TKROW = EDUCTRL_NUM_TKROW,
    parameter int TKROW_BW  = EDUCTRL_TKROWADDR_BW,
    parameter int SPIKE_TMO = EDUCTRL_SPIKE_TMO,
    parameter int TMO_BW    = $clog2(SPIKE_TMO + 1)
) (
    input logic               clk,
    input logic               rst_n,
    edu_round_ctrl_if.master  bus
);
    localparam logic [TKROW_BW-1:0] LAST_ROW = TKROW_BW'(NUM_TKROW - 1);

    educ_state_t         state, state_next;
    logic [TKROW_BW-1:0] rowidx;
    logic                last_round;
    logic                tmo_err;
    logic                tmo_hit;

    edu_match_timer #(
        .SPIKE_TMO (SPIKE_TMO),
        .TMO_BW    (TMO_BW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == EDUCTRL_SHIFT),
        .en    (state == EDUCTRL_MATCH),
        .tmo   (tmo_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EDUCTRL_IDLE;
            rowidx     <= '0;
            last_round <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                EDUCTRL_IDLE: begin
                    if (bus.round_start) begin
                        last_round <= bus.round_last;
                        tmo_err    <= 1'b0;
                    end
                end
                EDUCTRL_INIT:   rowidx <= '0;
                EDUCTRL_SHIFT: begin
                    if (!bus.any_tokenmatch && rowidx != LAST_ROW)
                        rowidx <= rowidx + TKROW_BW'(1);
                end
                EDUCTRL_MATCH: begin
                    if (!bus.any_errormatch && !bus.any_measmatch && tmo_hit)
                        tmo_err <= 1'b1;
                end
                EDUCTRL_FINISH: rowidx <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next                = state;
        bus.set_first_aqmeas      = 1'b0;
        bus.wr_zeroesm            = 1'b0;
        bus.pop_aqmeasbuf         = 1'b0;
        bus.rst_cellstate         = 1'b0;
        bus.shift_token           = 1'b0;
        bus.token_finish          = 1'b0;
        bus.token_in              = 1'b0;
        bus.flag_in               = 1'b0;
        bus.global_tokenmatch     = 1'b0;
        bus.global_errormatch     = 1'b0;
        bus.global_measmatch      = 1'b0;
        bus.set_measerr_flag      = 1'b0;
        bus.set_last_measerr_flag = 1'b0;
        bus.apply_aqmeas_flip     = 1'b0;
        bus.round_done            = 1'b0;
        case (state)
            EDUCTRL_IDLE: begin
                if (bus.round_start)
                    state_next = bus.round_zero ? EDUCTRL_ESMWR : EDUCTRL_WAITBUF;
            end
            EDUCTRL_WAITBUF: begin
                if (bus.all_aqmeasbuf_valid) begin
                    bus.pop_aqmeasbuf = 1'b1;
                    state_next        = EDUCTRL_INIT;
                end
            end
            EDUCTRL_ESMWR: begin
                bus.wr_zeroesm = 1'b1;
                state_next     = EDUCTRL_INIT;
            end
            EDUCTRL_INIT: begin
                bus.rst_cellstate = 1'b1;
                bus.token_in      = 1'b1;
                bus.shift_token   = 1'b1;
                state_next        = EDUCTRL_SHIFT;
            end
            EDUCTRL_SHIFT: begin
                if (bus.any_tokenmatch) begin
                    bus.global_tokenmatch = 1'b1;
                    state_next            = EDUCTRL_MATCH;
                end else if (rowidx == LAST_ROW) begin
                    state_next = EDUCTRL_FINISH;
                end else begin
                    bus.shift_token = 1'b1;
                end
            end
            EDUCTRL_MATCH: begin
                // Error response wins over measurement response, which wins over timeout.
                if (bus.any_errormatch) begin
                    bus.global_errormatch = 1'b1;
                    state_next            = EDUCTRL_CLEAR;
                end else if (bus.any_measmatch) begin
                    bus.global_measmatch      = 1'b1;
                    bus.set_measerr_flag      = 1'b1;
                    bus.set_last_measerr_flag = last_round;
                    state_next                = EDUCTRL_CLEAR;
                end else if (tmo_hit) begin
                    state_next = EDUCTRL_CLEAR;
                end
            end
            EDUCTRL_CLEAR: begin
                bus.rst_cellstate = 1'b1;
                state_next        = EDUCTRL_SHIFT;
            end
            EDUCTRL_FINISH: begin
                bus.token_finish      = 1'b1;
                bus.round_done        = 1'b1;
                bus.apply_aqmeas_flip = last_round;
                bus.set_first_aqmeas  = last_round;
                state_next            = EDUCTRL_IDLE;
            end
            default: state_next = EDUCTRL_IDLE;
        endcase
    end

    assign bus.curr_rowidx = rowidx;
    assign bus.busy        = (state != EDUCTRL_IDLE);
    assign bus.tmo_err     = tmo_err;
endmodule

// File: tb/tb_edu_round_ctrl.sv
// Bench for edu_round_ctrl: rounds are scripted as timelines and expanded into per-cycle expectations.
module tb_edu_round_ctrl;
    localparam int NROW = 8;
    localparam int TMO  = 16;

    typedef struct packed {
        logic rs, rz, rl, valid, tok, err, meas;
    } stim_t;

    typedef struct packed {
        logic set_first, wr_zero, pop, rst_cell, shift, finish, tin, fin;
        logic gtok, gerr, gmeas, smerr, slmerr, flip, busy, done, tmo;
        logic [2:0] row;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   round_no = 0;
    logic tmo_m = 1'b0;
    stim_t stim_q[$];
    obs_t  exp_q[$];

    edu_round_ctrl_if #(.TKROW_BW(3)) bus ();

    edu_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.round_start         = s.rs;
        bus.round_zero          = s.rz;
        bus.round_last          = s.rl;
        bus.all_aqmeasbuf_valid = s.valid;
        bus.any_tokenmatch      = s.tok;
        bus.any_errormatch      = s.err;
        bus.any_measmatch       = s.meas;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.set_first = bus.set_first_aqmeas;
        o.wr_zero   = bus.wr_zeroesm;
        o.pop       = bus.pop_aqmeasbuf;
        o.rst_cell  = bus.rst_cellstate;
        o.shift     = bus.shift_token;
        o.finish    = bus.token_finish;
        o.tin       = bus.token_in;
        o.fin       = bus.flag_in;
        o.gtok      = bus.global_tokenmatch;
        o.gerr      = bus.global_errormatch;
        o.gmeas     = bus.global_measmatch;
        o.smerr     = bus.set_measerr_flag;
        o.slmerr    = bus.set_last_measerr_flag;
        o.flip      = bus.apply_aqmeas_flip;
        o.busy      = bus.busy;
        o.done      = bus.round_done;
        o.tmo       = bus.tmo_err;
        o.row       = bus.curr_rowidx;
        return o;
    endfunction

    // Irrelevant inputs are randomized, including stray round_start pulses while busy.
    function automatic stim_t noise();
        stim_t s;
        s.rs    = ($urandom_range(0, 7) == 0);
        s.rz    = 1'($urandom);
        s.rl    = 1'($urandom);
        s.valid = 1'($urandom);
        s.tok   = 1'($urandom);
        s.err   = 1'($urandom);
        s.meas  = 1'($urandom);
        return s;
    endfunction

    function automatic obs_t busy_obs(input int row);
        obs_t e = '0;
        e.busy = 1'b1;
        e.tmo  = tmo_m;
        e.row  = 3'(row);
        return e;
    endfunction

    task automatic add(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // kind: 0-1 error, 2-3 measurement, 4-5 both, 6 no response (timeout)
    task automatic build_round(input bit zero, input bit last, input int waitc,
                               input bit rnd_match, input int frow, input int fkind, input int fd);
        stim_t s;
        obs_t  e;
        int    kind;
        int    d;
        bit    m;
        s = noise(); s.rs = 1'b1; s.rz = zero; s.rl = last;
        e = '0; e.tmo = tmo_m;
        add(s, e);
        tmo_m = 1'b0;
        if (zero) begin
            s = noise(); e = busy_obs(0); e.wr_zero = 1'b1; add(s, e);
        end else begin
            repeat (waitc) begin
                s = noise(); s.valid = 1'b0; add(s, busy_obs(0));
            end
            s = noise(); s.valid = 1'b1; e = busy_obs(0); e.pop = 1'b1; add(s, e);
        end
        s = noise(); e = busy_obs(0); e.rst_cell = 1'b1; e.tin = 1'b1; e.shift = 1'b1; add(s, e);
        for (int r = 0; r < NROW; r++) begin
            m = 1'b0; kind = 0; d = 0;
            if (r == frow) begin
                m = 1'b1; kind = fkind; d = fd;
            end else if (rnd_match && $urandom_range(0, 3) == 0) begin
                m = 1'b1; kind = $urandom_range(0, 6); d = $urandom_range(0, 5);
            end
            if (m) begin
                s = noise(); s.tok = 1'b1; e = busy_obs(r); e.gtok = 1'b1; add(s, e);
                if (kind == 6) begin
                    for (int k = 0; k <= TMO; k++) begin
                        s = noise(); s.err = 1'b0; s.meas = 1'b0; add(s, busy_obs(r));
                    end
                    tmo_m = 1'b1;
                end else begin
                    repeat (d) begin
                        s = noise(); s.err = 1'b0; s.meas = 1'b0; add(s, busy_obs(r));
                    end
                    s = noise();
                    s.err  = (kind < 2) || (kind >= 4);
                    s.meas = (kind >= 2);
                    e = busy_obs(r);
                    if (s.err) e.gerr = 1'b1;
                    else begin
                        e.gmeas = 1'b1; e.smerr = 1'b1; e.slmerr = last;
                    end
                    add(s, e);
                end
                s = noise(); e = busy_obs(r); e.rst_cell = 1'b1; add(s, e);
            end
            s = noise(); s.tok = 1'b0; e = busy_obs(r); e.shift = (r != NROW - 1); add(s, e);
        end
        s = noise(); e = busy_obs(NROW - 1);
        e.finish = 1'b1; e.done = 1'b1; e.flip = last; e.set_first = last;
        add(s, e);
        s = noise(); s.rs = 1'b0; e = '0; e.tmo = tmo_m; add(s, e);
    endtask

    task automatic run_queue(input int limit);
        stim_t s;
        obs_t  e;
        int    n = 0;
        while (stim_q.size() > 0 && n < limit) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            drive(s);
            #2;
            chk($sformatf("round%0d_cyc%0d", round_no, n), 32'(sample()), 32'(e));
            n++;
        end
        stim_q.delete();
        exp_q.delete();
        round_no++;
    endtask

    initial begin
        drive('0);
        repeat (2) @(negedge clk);
        #2;
        chk("reset_state", 32'(sample()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("idle_after_reset", 32'(sample()), 32'h0);

        build_round(1'b1, 1'b0, 0, 1'b0, -1, 0, 0); run_queue(1000);
        build_round(1'b0, 1'b0, 5, 1'b0, -1, 0, 0); run_queue(1000);
        build_round(1'b1, 1'b0, 0, 1'b0, 3, 0, 4);  run_queue(1000);
        build_round(1'b1, 1'b0, 0, 1'b0, 2, 4, 1);  run_queue(1000);
        build_round(1'b0, 1'b1, 2, 1'b0, 5, 2, 0);  run_queue(1000);
        build_round(1'b1, 1'b0, 0, 1'b0, 4, 6, 0);  run_queue(1000);
        build_round(1'b1, 1'b0, 0, 1'b0, -1, 0, 0); run_queue(1000);
        build_round(1'b0, 1'b1, 0, 1'b0, 7, 6, 0);  run_queue(1000);

        for (int i = 0; i < 30; i++) begin
            build_round(1'($urandom), 1'($urandom), $urandom_range(0, 4), 1'b1, -1, 0, 0);
            run_queue(1000);
        end

        // Abort in MATCH: row-1 match with a long response delay, cut two cycles into the wait.
        build_round(1'b1, 1'b0, 0, 1'b0, 1, 0, 10);
        run_queue(7);
        #1;
        bus.any_tokenmatch = 1'b1;
        bus.any_measmatch  = 1'b1;
        bus.any_errormatch = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_in_match", 32'(sample()), 32'h0);
        repeat (3) @(negedge clk);
        #2;
        chk("held_in_reset", 32'(sample()), 32'h0);
        @(negedge clk);
        drive('0);
        rst_n = 1'b1;
        tmo_m = 1'b0;
        #2;
        chk("idle_after_abort", 32'(sample()), 32'h0);
        build_round(1'b0, 1'b1, 1, 1'b1, 6, 1, 2);
        run_queue(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
